// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port.
// Accepted writes appear registered one cycle later; r0 writes are squashed.
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_Valid,
  input  logic [ADDR_W-1:0] req0_Addr,
  input  logic [DATA_W-1:0] req0_Data,
  output logic              req0_Ready,
  input  logic              req1_Valid,
  input  logic [ADDR_W-1:0] req1_Addr,
  input  logic [DATA_W-1:0] req1_Data,
  output logic              req1_Ready,
  output logic              write_Ena,
  output logic [ADDR_W-1:0] write_Addr,
  output logic [DATA_W-1:0] write_Data,
  output logic              grant_Id,
  output logic [7:0]        stall_Count
);

  logic              ptr;
  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic              stall;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // ptr=0 favours requester 0 when both are valid
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      unique case ({req1_Valid, req0_Valid})
        2'b01:   gnt0 = 1'b1;
        2'b10:   gnt1 = 1'b1;
        2'b11: begin
          gnt0 = ~ptr;
          gnt1 = ptr;
        end
        default: ;
      endcase
    end
  end

  assign req0_Ready = gnt0;
  assign req1_Ready = gnt1;
  assign xfer       = gnt0 | gnt1;
  assign sel_addr   = gnt1 ? req1_Addr : req0_Addr;
  assign sel_data   = gnt1 ? req1_Data : req0_Data;
  assign stall      = (req0_Valid & ~gnt0) | (req1_Valid & ~gnt1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (xfer) begin
      ptr <= ~gnt1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_Ena  <= 1'b0;
      write_Addr <= '0;
      write_Data <= '0;
      grant_Id   <= 1'b0;
    end else begin
      write_Ena <= xfer && (sel_addr != '0);
      if (xfer) begin
        write_Addr <= sel_addr;
        write_Data <= sel_data;
        grant_Id   <= gnt1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_Count <= 8'd0;
    end else if (stall && (stall_Count != 8'hFF)) begin
      stall_Count <= stall_Count + 8'd1;
    end
  end

endmodule
